// File: rtl/ddr_pkg.sv
// Shared DDR controller definitions: scheduler state encoding and
// clock-derived timing constants used by init, scheduler and signal-generate.
package ddr_pkg;

  localparam int CLK_PERIOD_PS = 7500;  // 133.33 MHz

  function automatic int ns_to_cycles(input int ns);
    return (ns * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
  endfunction

  localparam int TRP_CYCLES_DEF   = ns_to_cycles(20);  // tRP 20 ns
  localparam int TRFC_CYCLES_DEF  = ns_to_cycles(75);  // tRFC 75 ns
  // tREFI 7.8 us is 1040 cycles; issue slightly early to leave margin
  localparam int REF_INTERVAL_DEF = 1030;
  localparam int MAX_PEND_DEF     = 8;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    IDLE      = 3'd1,
    GRANT_WR  = 3'd2,
    GRANT_RD  = 3'd3,
    PRE       = 3'd4,
    PRE_WAIT  = 3'd5,
    REF       = 3'd6,
    REF_WAIT  = 3'd7
  } sched_state_t;

endpackage

// File: rtl/ddr_refresh_timer.sv
// Refresh interval counter with a saturating count of refreshes still owed
// and a sticky flag recording that one was lost to saturation.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int MAX_PEND     = MAX_PEND_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       dec,
  output logic [3:0] ref_pending,
  output logic       ref_overflow
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CNT_W-1:0] interval_reg;
  logic [3:0]       pending_reg;
  logic             overflow_reg;
  logic             inc_tick;

  assign inc_tick = enable && (interval_reg == CNT_W'(REF_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_reg <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else if (!enable) begin
      // overflow is deliberately retained across loss of init_done
      interval_reg <= '0;
      pending_reg  <= '0;
    end else begin
      interval_reg <= inc_tick ? '0 : interval_reg + 1'b1;
      case ({inc_tick, dec})
        2'b10: begin
          if (pending_reg == 4'(MAX_PEND)) overflow_reg <= 1'b1;
          else                             pending_reg  <= pending_reg + 1'b1;
        end
        2'b01: if (pending_reg != '0) pending_reg <= pending_reg - 1'b1;
        default: ;
      endcase
    end
  end

  assign ref_pending  = pending_reg;
  assign ref_overflow = overflow_reg;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Post-init DDR command scheduler: round-robin sharing of the datapath between
// write and read paths, with periodic PRECHARGE-ALL + AUTO REFRESH insertion.
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int TRP_CYCLES   = TRP_CYCLES_DEF,
  parameter int TRFC_CYCLES  = TRFC_CYCLES_DEF,
  parameter int MAX_PEND     = MAX_PEND_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       wr_req,
  input  logic       wr_done,
  output logic       wr_grant,
  input  logic       rd_req,
  input  logic       rd_done,
  output logic       rd_grant,
  output logic       pre_cmd,
  output logic       ref_cmd,
  output logic       busy,
  output logic [3:0] ref_pending,
  output logic       ref_overflow
);

  localparam int WAIT_MAX = (TRFC_CYCLES > TRP_CYCLES) ? TRFC_CYCLES : TRP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  sched_state_t      state_reg, state_next;
  logic              last_wr_reg, last_wr_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              pick_wr;

  ddr_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .MAX_PEND    (MAX_PEND)
  ) u_refresh_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (init_done),
    .dec         (state_reg == REF),
    .ref_pending (ref_pending),
    .ref_overflow(ref_overflow)
  );

  // Write wins unless read is also waiting and write was served last.
  assign pick_wr = wr_req && (!rd_req || !last_wr_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WAIT_INIT;
      last_wr_reg <= 1'b0;
      wait_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      last_wr_reg <= last_wr_next;
      wait_reg    <= wait_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_wr_next = last_wr_reg;
    wait_next    = wait_reg;
    case (state_reg)
      WAIT_INIT: if (init_done) state_next = IDLE;
      IDLE: begin
        // refresh owed takes precedence over any waiting request
        if (ref_pending != '0) begin
          state_next = PRE;
        end else if (wr_req || rd_req) begin
          state_next   = pick_wr ? GRANT_WR : GRANT_RD;
          last_wr_next = pick_wr;
        end
      end
      GRANT_WR: if (wr_done) state_next = IDLE;
      GRANT_RD: if (rd_done) state_next = IDLE;
      PRE: begin
        state_next = PRE_WAIT;
        wait_next  = WAIT_W'(TRP_CYCLES - 1);
      end
      PRE_WAIT: begin
        if (wait_reg == '0) state_next = REF;
        else                wait_next  = wait_reg - 1'b1;
      end
      REF: begin
        state_next = REF_WAIT;
        wait_next  = WAIT_W'(TRFC_CYCLES - 1);
      end
      REF_WAIT: begin
        if (wait_reg == '0) state_next = IDLE;
        else                wait_next  = wait_reg - 1'b1;
      end
      default: state_next = WAIT_INIT;
    endcase
    if (!init_done) begin
      state_next   = WAIT_INIT;
      last_wr_next = last_wr_reg;
    end
  end

  // Grants and pulses are gated by init_done so they drop in the same cycle.
  assign wr_grant = init_done && (state_reg == GRANT_WR);
  assign rd_grant = init_done && (state_reg == GRANT_RD);
  assign pre_cmd  = init_done && (state_reg == PRE);
  assign ref_cmd  = init_done && (state_reg == REF);
  assign busy     = (state_reg != IDLE) && (state_reg != WAIT_INIT);

endmodule
